fmq_cmd_tx: RTL and testbench
=============================

FMQ_CMD_TX -- requirements
Module: fmq_cmd_tx

Interface
REQ-001 Parameter TIMEOUT, 50000, response wait limit in clk cycles (1..2^20-1).
REQ-002 clk  input  1  system clock, all logic on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  command accepted when high together with cmd_valid.
REQ-006 cmd_op  input  2  opcode: 00 set-offset, 01 reload, 10 query-outputs, 11 reserved.
REQ-007 cmd_index  input  7  transducer index (op 00 only).
REQ-008 cmd_offset  input  12  phase offset (op 00 only).
REQ-009 m_axis_tdata  output  8  frame byte to UART transmitter.
REQ-010 m_axis_tvalid / m_axis_tready  output / input  1  AXI-stream handshake toward UART.
REQ-011 s_axis_tdata  input  8  byte received from UART.
REQ-012 s_axis_tvalid / s_axis_tready  input / output  1  AXI-stream handshake from UART.
REQ-013 rsp_data  output  8  response byte; rsp_valid output 1, one-cycle pulse.
REQ-014 rsp_timeout  output  1  one-cycle pulse when expected response not received.
REQ-015 rsp_stray  output  1  one-cycle pulse when a byte arrives outside WAIT_RSP.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 Frame SHALL be 3 bytes: B0={1,op[1:0],index[6:2]}, B1={0,index[1:0],offset[11:7]}, B2={0,offset[6:0]}.
REQ-018 For op != 00 the index and offset fields SHALL be transmitted as zero.
REQ-019 cmd_ready SHALL be high only in IDLE; op/index/offset SHALL be captured on the accepting edge.
REQ-020 States: IDLE -> SEND0 -> SEND1 -> SEND2 -> (WAIT_RSP if op is 10 or 11, else IDLE); WAIT_RSP -> IDLE.
REQ-021 m_axis_tvalid SHALL rise the cycle after acceptance with B0; each byte advances only on tvalid&&tready.
REQ-022 m_axis_tdata SHALL remain stable while tvalid is high and tready low; tvalid SHALL not drop without a transfer.
REQ-023 After the B2 transfer, state SHALL go directly to IDLE or WAIT_RSP, with no idle gap beyond one cycle.
REQ-024 Back-to-back commands: cmd_ready SHALL reassert the cycle after the final B2 transfer (non-query ops).
REQ-025 s_axis_tready SHALL be constantly high after reset; received bytes never back-pressure.
REQ-026 In WAIT_RSP a received byte SHALL drive rsp_data and pulse rsp_valid next cycle, then IDLE.
REQ-027 Timeout counter SHALL clear on entering WAIT_RSP; at count TIMEOUT-1 without a byte, pulse rsp_timeout, go IDLE.
REQ-028 Byte arriving on the same cycle the timeout expires SHALL win: rsp_valid, no rsp_timeout.
REQ-029 Bytes arriving outside WAIT_RSP SHALL be discarded and pulse rsp_stray; rsp_data unchanged.
REQ-030 rsp_data SHALL hold its last value until the next valid response.

Reset
REQ-031 On rst low: state IDLE, m_axis_tvalid 0, m_axis_tdata 0x00, cmd_ready 0, s_axis_tready 0, rsp_data 0x00, rsp_valid/rsp_timeout/rsp_stray 0, busy 0, counter 0.
REQ-032 First edge after release: cmd_ready 1, s_axis_tready 1.
REQ-033 Reset mid-frame SHALL abort immediately; the partial frame is not resumed.

Structure
REQ-034 Shared package SHALL hold opcode constants (OP_SET, OP_RELOAD, OP_QUERY, OP_RSVD), index width 7, offset width 12, frame-start bit position.
REQ-035 Single module, no sub-modules; the frame packer is a combinational function from the package.

Verification
REQ-036 Set op, index 87, offset 0xABC, tready=1 -> bytes 0x95, 0x75, 0x3C on consecutive cycles, no response wait.
REQ-037 Reload op, index 5, offset 0x123 -> bytes 0xA0, 0x00, 0x00; cmd_ready high the cycle after.
REQ-038 Query op, reply 0x58 after 100 cycles -> bytes 0xC0, 0x00, 0x00, then rsp_valid with rsp_data 0x58.
REQ-039 Query op, TIMEOUT=64, no reply -> rsp_timeout pulse 64 cycles after WAIT_RSP entry; byte on that same cycle -> rsp_valid only.
REQ-040 tready held low 10 cycles on B1 -> tdata 0x75 stable, tvalid high throughout; reset asserted then -> tvalid 0 immediately.
REQ-041 Byte 0x11 received in IDLE -> rsp_stray pulse, rsp_valid 0, rsp_data unchanged.

Source files
------------

// File: rtl/fmq_cmd_tx_pkg.sv
// fmq_cmd_tx_pkg: opcodes, field widths, FSM states and the frame packer shared by the command transmitter.
package fmq_cmd_tx_pkg;
  localparam logic [1:0] OP_SET = 2'b00;
  localparam logic [1:0] OP_RELOAD = 2'b01;
  localparam logic [1:0] OP_QUERY = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;
  localparam int INDEX_W = 7;
  localparam int OFFSET_W = 12;
  localparam int FRAME_START_BIT = 7;
  typedef enum logic [2:0] {IDLE, SEND0, SEND1, SEND2, WAIT_RSP} state_t;
  // Only the first byte carries the start bit, so the receiver can resync on any byte boundary.
  function automatic logic [23:0] pack_frame(input logic [1:0] op, input logic [INDEX_W-1:0] index,
                                             input logic [OFFSET_W-1:0] offset);
    logic [INDEX_W-1:0] i;
    logic [OFFSET_W-1:0] o;
    logic [7:0] b0;
    i = op == OP_SET ? index : '0;
    o = op == OP_SET ? offset : '0;
    b0 = {1'b0, op, i[6:2]};
    b0[FRAME_START_BIT] = 1'b1;
    return {b0, 1'b0, i[1:0], o[11:7], 1'b0, o[6:0]};
  endfunction
endpackage

// File: rtl/fmq_cmd_tx.sv
// fmq_cmd_tx: frames phase commands into 3 UART bytes and waits for the query response.
module fmq_cmd_tx
  import fmq_cmd_tx_pkg::*;
#(
  parameter int TIMEOUT = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [INDEX_W-1:0]  cmd_index,
  input  logic [OFFSET_W-1:0] cmd_offset,
  output logic [7:0]          m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  input  logic [7:0]          s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  output logic [7:0]          rsp_data,
  output logic                rsp_valid,
  output logic                rsp_timeout,
  output logic                rsp_stray,
  output logic                busy
);
  localparam int CW = 20;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);
  state_t st, nxt;
  logic alive, qry, rx;
  logic [23:0] frame;
  logic [CW-1:0] cnt;
  assign rx = s_axis_tvalid && s_axis_tready;
  assign s_axis_tready = alive;
  assign busy = st != IDLE;
  always_comb begin
    nxt = st;
    cmd_ready = alive && st == IDLE;
    m_axis_tvalid = st == SEND0 || st == SEND1 || st == SEND2;
    m_axis_tdata = st == SEND0 ? frame[23:16] : st == SEND1 ? frame[15:8] : st == SEND2 ? frame[7:0] : 8'h00;
    case (st)
      IDLE:     if (cmd_valid && cmd_ready) nxt = SEND0;
      SEND0:    if (m_axis_tready) nxt = SEND1;
      SEND1:    if (m_axis_tready) nxt = SEND2;
      SEND2:    if (m_axis_tready) nxt = qry ? WAIT_RSP : IDLE;
      WAIT_RSP: if (rx || cnt == LIMIT) nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= IDLE;
      alive <= 1'b0;
      qry <= 1'b0;
      frame <= '0;
      cnt <= '0;
      rsp_data <= 8'h00;
      rsp_valid <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_stray <= 1'b0;
    end else begin
      st <= nxt;
      alive <= 1'b1;
      cnt <= st == WAIT_RSP ? cnt + CW'(1) : '0;
      rsp_valid <= st == WAIT_RSP && rx;
      rsp_timeout <= st == WAIT_RSP && !rx && cnt == LIMIT;
      rsp_stray <= st != WAIT_RSP && rx;
      if (st == WAIT_RSP && rx) rsp_data <= s_axis_tdata;
      if (cmd_valid && cmd_ready) begin
        frame <= pack_frame(cmd_op, cmd_index, cmd_offset);
        qry <= cmd_op == OP_QUERY || cmd_op == OP_RSVD;
      end
    end
  end
endmodule

// File: tb/tb_fmq_cmd_tx.sv
// tb_fmq_cmd_tx: directed checks of framing, back-pressure, responses, timeout and stray bytes.
module tb_fmq_cmd_tx;
  logic clk = 0, rst = 0;
  logic cmd_valid = 0, m_axis_tready = 1, s_axis_tvalid = 0;
  logic [1:0] cmd_op = 0;
  logic [6:0] cmd_index = 0;
  logic [11:0] cmd_offset = 0;
  logic [7:0] s_axis_tdata = 0;
  logic cmd_ready, m_axis_tvalid, s_axis_tready, rsp_valid, rsp_timeout, rsp_stray, busy;
  logic [7:0] m_axis_tdata, rsp_data;
  logic l_cmd_ready, l_tvalid, l_s_tready, l_rsp_valid, l_rsp_timeout, l_rsp_stray, l_busy;
  logic [7:0] l_tdata, l_rsp_data;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  fmq_cmd_tx #(.TIMEOUT(64)) u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_index(cmd_index), .cmd_offset(cmd_offset), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .rsp_data(rsp_data),
    .rsp_valid(rsp_valid), .rsp_timeout(rsp_timeout), .rsp_stray(rsp_stray), .busy(busy));
  fmq_cmd_tx u_long (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(l_cmd_ready), .cmd_op(cmd_op),
    .cmd_index(cmd_index), .cmd_offset(cmd_offset), .m_axis_tdata(l_tdata),
    .m_axis_tvalid(l_tvalid), .m_axis_tready(m_axis_tready), .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(l_s_tready), .rsp_data(l_rsp_data),
    .rsp_valid(l_rsp_valid), .rsp_timeout(l_rsp_timeout), .rsp_stray(l_rsp_stray), .busy(l_busy));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [1:0] op, input logic [6:0] idx, input logic [11:0] off);
    cmd_valid = 1; cmd_op = op; cmd_index = idx; cmd_offset = off;
    tick();
    cmd_valid = 0;
  endtask
  task automatic bytes3(input string tag, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    chk({tag, "_v0"}, m_axis_tvalid, 1);
    chk({tag, "_b0"}, m_axis_tdata, b0);
    tick();
    chk({tag, "_b1"}, m_axis_tdata, b1);
    tick();
    chk({tag, "_b2"}, m_axis_tdata, b2);
    tick();
  endtask
  initial begin
    tick(2);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_s_tready", s_axis_tready, 0);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_busy", busy, 0);
    rst = 1;
    tick();
    chk("rel_cmd_ready", cmd_ready, 1);
    chk("rel_s_tready", s_axis_tready, 1);
    send(2'b00, 7'd87, 12'hABC);
    chk("set_busy", busy, 1);
    chk("set_no_ready", cmd_ready, 0);
    bytes3("set", 8'h95, 8'h75, 8'h3C);
    chk("set_done_ready", cmd_ready, 1);
    chk("set_done_valid", m_axis_tvalid, 0);
    send(2'b01, 7'd5, 12'h123);
    bytes3("reload", 8'hA0, 8'h00, 8'h00);
    chk("reload_ready", cmd_ready, 1);
    chk("reload_busy", busy, 0);
    s_axis_tvalid = 1; s_axis_tdata = 8'h11;
    tick();
    s_axis_tvalid = 0;
    chk("stray_pulse", rsp_stray, 1);
    chk("stray_no_valid", rsp_valid, 0);
    chk("stray_data", rsp_data, 8'h00);
    tick();
    chk("stray_end", rsp_stray, 0);
    // Default-TIMEOUT instance answers after 100 cycles in WAIT_RSP.
    send(2'b10, 7'd0, 12'd0);
    bytes3("query", 8'hC0, 8'h00, 8'h00);
    chk("long_wait_busy", l_busy, 1);
    tick(99);
    chk("long_pre_valid", l_rsp_valid, 0);
    s_axis_tvalid = 1; s_axis_tdata = 8'h58;
    tick();
    s_axis_tvalid = 0;
    chk("long_rsp_valid", l_rsp_valid, 1);
    chk("long_rsp_data", l_rsp_data, 8'h58);
    chk("long_no_timeout", l_rsp_timeout, 0);
    chk("long_idle", l_busy, 0);
    tick();
    chk("long_pulse_end", l_rsp_valid, 0);
    chk("long_data_hold", l_rsp_data, 8'h58);
    chk("short_data_kept", rsp_data, 8'h00);
    send(2'b11, 7'd9, 12'd77);
    bytes3("rsvd", 8'hE0, 8'h00, 8'h00);
    tick(63);
    chk("to_pre", rsp_timeout, 0);
    chk("to_pre_busy", busy, 1);
    tick();
    chk("to_pulse", rsp_timeout, 1);
    chk("to_no_valid", rsp_valid, 0);
    chk("to_idle", busy, 0);
    tick();
    chk("to_pulse_end", rsp_timeout, 0);
    send(2'b10, 7'd1, 12'd1);
    bytes3("race", 8'hC0, 8'h00, 8'h00);
    tick(63);
    s_axis_tvalid = 1; s_axis_tdata = 8'hA5;
    tick();
    s_axis_tvalid = 0;
    chk("race_valid", rsp_valid, 1);
    chk("race_no_timeout", rsp_timeout, 0);
    chk("race_data", rsp_data, 8'hA5);
    tick();
    send(2'b00, 7'd87, 12'hABC);
    chk("bp_b0", m_axis_tdata, 8'h95);
    tick();
    m_axis_tready = 0;
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", m_axis_tvalid, 1);
      chk("bp_data", m_axis_tdata, 8'h75);
      tick();
    end
    rst = 0;
    #1;
    chk("abort_valid", m_axis_tvalid, 0);
    chk("abort_data", m_axis_tdata, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", cmd_ready, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
